// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard and sequencing control for the deco/exe/mem/wb pipeline.
// It drives the EXE operand forwarding selects and inserts load-use bubbles.
// It flushes the pipeline on a taken branch.
// It sequences the multi-cycle trig unit, stalling the front end until the unit reports done.
// Optional build macro HAZARD_PERF_CNT_EN adds a saturating stall-cycle counter on stall_count.
// Without that macro, stall_count is tied to zero.
module pipeline_hazard_ctrl #(
  parameter int unsigned TRIG_TIMEOUT = 64,
  parameter logic [3:0]  PC_REG       = 4'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_valid,
  input  logic [3:0]  d_rn,
  input  logic [3:0]  d_rs,
  input  logic        e_valid,
  input  logic [3:0]  e_rd,
  input  logic        e_reg_write,
  input  logic [1:0]  e_mem_to_reg,
  input  logic        e_trig_select,
  input  logic        e_pc_src,
  input  logic [3:0]  m_rd,
  input  logic        m_reg_write,
  input  logic [3:0]  w_rd,
  input  logic        w_reg_write,
  input  logic        trig_done,
  output logic        trig_start,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        flush_d,
  output logic        flush_e,
  output logic        trig_timeout,
  output logic [31:0] stall_count
);

  localparam int unsigned CNT_W = (TRIG_TIMEOUT > 1) ? $clog2(TRIG_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRIG_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  logic [1:0]       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             timeout_d, timeout_q;

  logic trig_go;
  logic trig_start_c;
  logic trig_stall;
  logic err_flush;
  logic lu;
  logic branch;

  // MEM result has priority over WB; the PC alias register is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [3:0] src,
                                         input logic [3:0] mrd, input logic mwe,
                                         input logic [3:0] wrd, input logic wwe);
    if (mwe && (mrd == src) && (mrd != PC_REG))
      return 2'b10;
    else if (wwe && (wrd == src) && (wrd != PC_REG))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Hazard detection: load-use dependency and taken branch in EXE.
  always_comb begin
    lu      = d_valid && e_valid && e_reg_write && (e_mem_to_reg == 2'b01) &&
              ((e_rd == d_rn) || (e_rd == d_rs));
    branch  = e_valid && e_pc_src;
    trig_go = e_valid && e_trig_select && !e_pc_src;
  end

  // Trig sequencer next state: start, wait for done or time out, then one error cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    trig_start_c = 1'b0;
    trig_stall   = 1'b0;
    err_flush    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_go) begin
          trig_start_c = 1'b1;
          trig_stall   = 1'b1;
          cnt_d        = '0;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (trig_done) begin
          state_d = ST_IDLE;
        end else begin
          trig_stall = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d   = ST_ERR;
            timeout_d = 1'b1;
          end
        end
      end
      ST_ERR: begin
        err_flush = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Output merge: a trig stall masks load-use, and a branch cancels the load-use stall of fetch/deco.
  always_comb begin
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    trig_start   = 1'b0;
    trig_timeout = 1'b0;
    if (!rst) begin
      fwd_a        = fwd_sel(d_rn, m_rd, m_reg_write, w_rd, w_reg_write);
      fwd_b        = fwd_sel(d_rs, m_rd, m_reg_write, w_rd, w_reg_write);
      stall_e      = trig_stall;
      stall_f      = trig_stall || (lu && !trig_stall && !branch);
      stall_d      = trig_stall || (lu && !trig_stall && !branch);
      flush_d      = branch;
      flush_e      = branch || (lu && !trig_stall) || err_flush;
      trig_start   = trig_start_c;
      trig_timeout = timeout_q;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;

  // Saturating count of cycles with fetch stalled.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_f && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = rst ? '0 : stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule
